phys_free_list: RTL and testbench

Physical-register free list for the rename stage. It hands out free physical register numbers to rename. The commit stage returns the previous mapping of each retiring destination. On a commit-stage misprediction it rolls speculative allocations back to the committed point in one cycle.

---
 rtl/phys_free_list.sv | 126 ++++++++++++
 tb/tb_phys_free_list.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Physical-register free list for rename: circular FIFO of free register numbers with a
// speculative head that rolls back to the committed head on mispredict. Define FREE_LIST_CHECK_EN for the integrity bitmap and sticky error_o.
module phys_free_list #(
    parameter int NUM_PHYS_REG = 32,
    parameter int NUM_ARCH_REG = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            alloc_v_i,
    output logic                            alloc_ready_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] alloc_reg_o,
    input  logic                            commit_v_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] commit_old_reg_i,
    input  logic                            mispredict_i,
    output logic [$clog2(NUM_PHYS_REG):0]   free_count_o,
    output logic                            error_o
);

    localparam int IW = $clog2(NUM_PHYS_REG);
    localparam int PW = IW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [IW-1:0] mem [NUM_PHYS_REG];
    ptr_t          spec_head;
    ptr_t          commit_head;
    ptr_t          tail;
    ptr_t          spec_head_nxt;
    ptr_t          commit_head_nxt;
    ptr_t          tail_nxt;
    logic          alloc_fire;

    assign free_count_o  = tail - spec_head;
    assign alloc_ready_o = (free_count_o != '0) && !mispredict_i;
    assign alloc_reg_o   = mem[spec_head[IW-1:0]];
    assign alloc_fire    = alloc_v_i && alloc_ready_o;

    // Each retirement consumes the oldest allocation, so commit_head tracks tail one-for-one.
    always_comb begin
        commit_head_nxt = commit_head + {{IW{1'b0}}, commit_v_i};
        tail_nxt        = tail + {{IW{1'b0}}, commit_v_i};
        if (mispredict_i) begin
            spec_head_nxt = commit_head_nxt;
        end else begin
            spec_head_nxt = spec_head + {{IW{1'b0}}, alloc_fire};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= PW'(NUM_PHYS_REG - NUM_ARCH_REG);
        end else begin
            spec_head   <= spec_head_nxt;
            commit_head <= commit_head_nxt;
            tail        <= tail_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PHYS_REG; i++) begin
                mem[i] <= (i < NUM_PHYS_REG - NUM_ARCH_REG) ? IW'(NUM_ARCH_REG + i) : '0;
            end
        end else if (commit_v_i) begin
            mem[tail[IW-1:0]] <= commit_old_reg_i;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PHYS_REG-1:0] in_list;
    logic [NUM_PHYS_REG-1:0] in_list_nxt;
    logic                    error_q;
    logic                    error_set;
    logic                    dup_commit;
    ptr_t                    window;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           entry;

    // On mispredict the bitmap is rebuilt from the restored window, including this cycle's commit write.
    always_comb begin
        in_list_nxt = in_list;
        window      = tail_nxt - spec_head_nxt;
        idx         = '0;
        entry       = '0;
        if (alloc_fire) begin
            in_list_nxt[alloc_reg_o] = 1'b0;
        end
        if (commit_v_i) begin
            in_list_nxt[commit_old_reg_i] = 1'b1;
        end
        if (mispredict_i) begin
            in_list_nxt = '0;
            for (int k = 0; k < NUM_PHYS_REG; k++) begin
                idx   = spec_head_nxt[IW-1:0] + IW'(k);
                entry = (commit_v_i && (idx == tail[IW-1:0])) ? commit_old_reg_i : mem[idx];
                if (PW'(k) < window) begin
                    in_list_nxt[entry] = 1'b1;
                end
            end
        end
    end

    assign dup_commit = in_list[commit_old_reg_i] && !(alloc_fire && (alloc_reg_o == commit_old_reg_i));
    assign error_set  = (commit_v_i && (dup_commit || (commit_head == spec_head)))
                      || ((tail_nxt - spec_head_nxt) > PW'(NUM_PHYS_REG));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PHYS_REG; i++) begin
                in_list[i] <= (i >= NUM_ARCH_REG);
            end
            error_q <= 1'b0;
        end else begin
            in_list <= in_list_nxt;
            error_q <= error_q | error_set;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized legal traffic.
module tb_phys_free_list;

    localparam int P = 32;
    localparam int A = 8;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       alloc_v_i = 1'b0;
    logic       alloc_ready_o;
    logic [4:0] alloc_reg_o;
    logic       commit_v_i = 1'b0;
    logic [4:0] commit_old_reg_i = '0;
    logic       mispredict_i = 1'b0;
    logic [5:0] free_count_o;
    logic       error_o;

    int checks = 0;
    int errors = 0;

    phys_free_list #(.NUM_PHYS_REG(P), .NUM_ARCH_REG(A)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .alloc_v_i        (alloc_v_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_reg_o      (alloc_reg_o),
        .commit_v_i       (commit_v_i),
        .commit_old_reg_i (commit_old_reg_i),
        .mispredict_i     (mispredict_i),
        .free_count_o     (free_count_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: q holds registers from the committed head to the tail; spec_off counts uncommitted grants.
    int q[$];
    int pool[$];
    int spec_off;
    bit m_err;

    always @(posedge clk_i or posedge reset_i) begin
        int fire;
        if (reset_i) begin
            q.delete();
            pool.delete();
            for (int i = A; i < P; i++) q.push_back(i);
            for (int i = 0; i < A; i++) pool.push_back(i);
            spec_off = 0;
            m_err    = 0;
        end else begin
            fire = (alloc_v_i && (q.size() - spec_off) != 0 && !mispredict_i) ? 1 : 0;
            if (commit_v_i) begin
`ifdef FREE_LIST_CHECK_EN
                if (spec_off == 0) m_err = 1;
                for (int k = spec_off + fire; k < q.size(); k++)
                    if (q[k] == int'(commit_old_reg_i)) m_err = 1;
`endif
                for (int k = 0; k < pool.size(); k++) begin
                    if (pool[k] == int'(commit_old_reg_i)) begin
                        pool.delete(k);
                        break;
                    end
                end
                pool.push_back(q[0]);
                q.push_back(int'(commit_old_reg_i));
                void'(q.pop_front());
            end
            spec_off = mispredict_i ? 0 : spec_off + fire - (commit_v_i ? 1 : 0);
`ifdef FREE_LIST_CHECK_EN
            if (q.size() - spec_off > P) m_err = 1;
`endif
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic cv, input int old, input logic mis);
        alloc_v_i        = av;
        commit_v_i       = cv;
        commit_old_reg_i = 5'(old);
        mispredict_i     = mis;
    endtask

    task automatic step(input logic av, input logic cv, input int old, input logic mis);
        @(posedge clk_i);
        #1;
        applyStimulus(av, cv, old, mis);
        @(negedge clk_i);
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        applyStimulus(0, 0, 0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic compareLoop();
        int exp_free;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                exp_free = q.size() - spec_off;
                checkOutput("free_count", int'(free_count_o), exp_free);
                checkOutput("alloc_ready", int'(alloc_ready_o), (exp_free != 0 && !mispredict_i) ? 1 : 0);
                if (exp_free != 0 && !mispredict_i && spec_off >= 0)
                    checkOutput("alloc_reg", int'(alloc_reg_o), q[spec_off]);
                checkOutput("error", int'(error_o), int'(m_err));
            end
        end
    endtask

    initial begin
        int inflight[$];
        int drained[$];
        int cnt[P];
        int good;
        int old;
        logic av;
        logic cv;
        logic mis;
        bit done;

        @(negedge clk_i);
        checkOutput("reset_free_count", int'(free_count_o), 24);
        checkOutput("reset_ready", int'(alloc_ready_o), 1);
        checkOutput("reset_alloc_reg", int'(alloc_reg_o), 8);
        checkOutput("reset_error", int'(error_o), 0);
        fork
            compareLoop();
        join_none

        // Scenario 1: three grants after reset release.
        doReset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            checkOutput("s1_grant", int'(alloc_reg_o), 8 + i);
        end
        step(0, 0, 0, 0);
        checkOutput("s1_free", int'(free_count_o), 21);

        // Scenario 2: drain to empty, then a commit is not bypassed.
        doReset();
        for (int i = 0; i < 24; i++) step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        checkOutput("s2_empty_ready", int'(alloc_ready_o), 0);
        step(0, 0, 0, 0);
        checkOutput("s2_refill_ready", int'(alloc_ready_o), 1);
        checkOutput("s2_refill_reg", int'(alloc_reg_o), 3);

        // Scenario 3: mispredict rolls back to the committed head.
        doReset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 2, 0);
        step(1, 0, 0, 1);
        checkOutput("s3_mis_ready", int'(alloc_ready_o), 0);
        step(0, 0, 0, 0);
        checkOutput("s3_restored_reg", int'(alloc_reg_o), 10);
        checkOutput("s3_restored_free", int'(free_count_o), 24);

        // Scenario 4: simultaneous allocate and commit.
        doReset();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 5, 0);
            checkOutput("s4_grant", int'(alloc_reg_o), 8 + i);
            checkOutput("s4_free", int'(free_count_o), 24);
        end
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        checkOutput("s4_fifo_reg5", int'(alloc_reg_o), 5);

        // Scenario 5: 60 allocate/commit pairs across the wrap, then drain and check conservation.
        doReset();
        inflight.delete();
        drained.delete();
        step(1, 0, 0, 0);
        if (alloc_ready_o) inflight.push_back(int'(alloc_reg_o));
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i);
            #1;
            old = pool[$urandom_range(0, pool.size() - 1)];
            applyStimulus(1, 1, old, 0);
            @(negedge clk_i);
            if (inflight.size() > 0) void'(inflight.pop_front());
            if (alloc_ready_o) inflight.push_back(int'(alloc_reg_o));
        end
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(1, 0, 0, 0);
            if (alloc_ready_o) drained.push_back(int'(alloc_reg_o));
            else done = 1;
        end
        step(0, 0, 0, 0);
        for (int r = 0; r < P; r++) cnt[r] = 0;
        foreach (pool[k]) cnt[pool[k]]++;
        foreach (inflight[k]) cnt[inflight[k]]++;
        foreach (drained[k]) cnt[drained[k]]++;
        good = 0;
        for (int r = 0; r < P; r++) if (cnt[r] == 1) good++;
        checkOutput("s5_conservation", good, P);

        // Scenario 6: returning a register that is still free.
        doReset();
        step(1, 0, 0, 0);
        step(0, 1, 20, 0);
        step(0, 0, 0, 0);
`ifdef FREE_LIST_CHECK_EN
        checkOutput("s6_error_set", int'(error_o), 1);
`else
        checkOutput("s6_error_set", int'(error_o), 0);
`endif
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        doReset();
        checkOutput("s6_error_cleared", int'(error_o), 0);

        // Randomized legal traffic: commits only retire outstanding grants, old regs from the architected pool.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_i);
            #1;
            av  = ($urandom_range(0, 9) < 7);
            cv  = (spec_off > 0) && ($urandom_range(0, 9) < 4);
            old = cv ? pool[$urandom_range(0, pool.size() - 1)] : 0;
            mis = ($urandom_range(0, 31) == 0);
            applyStimulus(av, cv, old, mis);
            @(negedge clk_i);
        end

        // Asynchronous reset mid-operation.
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("async_reset_free", int'(free_count_o), 24);
        checkOutput("async_reset_reg", int'(alloc_reg_o), 8);
        checkOutput("async_reset_ready", int'(alloc_ready_o), 1);
        doReset();
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
